paint_grid_tracker: RTL and testbench

Parametrised cursor-driven paint grid for the VGA pipeline: push buttons move a cursor over a HCELLS×VCELLS cell grid, cells under the cursor are painted or erased, and the raster lookup returns a per-pixel `on` bit for the current `hcnt`/`vcnt`. It replaces the fixed two-resolution tracker with the following:
- arbitrary grid size and power-of-two cell size;
- four-way movement with wrap-around;
- erase and sequenced clear;
- an incrementally maintained painted-pixel count.

It sits between the button debouncer and the pixel mux.

---
 rtl/paint_grid_pkg.sv | 20 ++
 rtl/btn_edge_prio.sv | 38 +++
 rtl/paint_grid_tracker.sv | 132 +++++++++++++
 tb/tb_paint_grid_tracker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_grid_pkg.sv
// Shared types and helpers for the cursor-driven paint grid.
package paint_grid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [1:0] BTN_RIGHT = 2'd0;
  localparam logic [1:0] BTN_UP    = 2'd1;
  localparam logic [1:0] BTN_DOWN  = 2'd2;
  localparam logic [1:0] BTN_LEFT  = 2'd3;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/btn_edge_prio.sv
// Button rising-edge detector producing one prioritised one-hot move per cycle.
module btn_edge_prio
  import paint_grid_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] buttons,
  output logic [3:0] move_c
);

  logic [3:0] prev;
  logic [3:0] edges;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= buttons;
    end
  end

  assign edges = buttons & ~prev;

  // Right beats left beats up beats down; losers are dropped, not queued.
  always_comb begin
    move_c = '0;
    if (edges[BTN_RIGHT]) begin
      move_c[BTN_RIGHT] = 1'b1;
    end else if (edges[BTN_LEFT]) begin
      move_c[BTN_LEFT] = 1'b1;
    end else if (edges[BTN_UP]) begin
      move_c[BTN_UP] = 1'b1;
    end else if (edges[BTN_DOWN]) begin
      move_c[BTN_DOWN] = 1'b1;
    end
  end

endmodule

// File: rtl/paint_grid_tracker.sv
// Cursor-driven paint grid: button movement, paint/erase, sequenced clear,
// painted-pixel count and a two-stage raster lookup.
module paint_grid_tracker
  import paint_grid_pkg::*;
#(
  parameter int unsigned HCELLS    = 96,
  parameter int unsigned VCELLS    = 54,
  parameter int unsigned CELL_LOG2 = 3,
  parameter int unsigned CNT_W     = 20
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [3:0]                PushButton,
  input  logic                      pen,
  input  logic                      erase,
  input  logic                      clear,
  input  logic [13:0]               hcnt,
  input  logic [11:0]               vcnt,
  output logic                      on,
  output logic                      busy,
  output logic [idx_w(HCELLS)-1:0]  cursor_col,
  output logic [idx_w(VCELLS)-1:0]  cursor_row,
  output logic [CNT_W-1:0]          pixel_cnt
);

  localparam int unsigned NCELLS = HCELLS * VCELLS;
  localparam int unsigned COL_W  = idx_w(HCELLS);
  localparam int unsigned ROW_W  = idx_w(VCELLS);
  localparam int unsigned IDX_W  = idx_w(NCELLS);
  localparam int unsigned PC_W   = idx_w(NCELLS + 1);

  state_t            state;
  logic [NCELLS-1:0] grid;
  logic [IDX_W-1:0]  sweep;
  logic [PC_W-1:0]   painted;
  logic [IDX_W-1:0]  lk_idx;
  logic              lk_ok;
  logic [3:0]        move_c;

  logic [13:0]       col_full_c;
  logic [11:0]       row_full_c;
  logic              in_range_c;
  logic [IDX_W-1:0]  lookup_idx_c;
  logic [IDX_W-1:0]  cur_idx_c;

  btn_edge_prio u_btn (
    .clk     (CLK),
    .rst_n   (RESET),
    .buttons (PushButton),
    .move_c  (move_c)
  );

  // Raster pixel to cell index; out-of-grid pixels never read the grid.
  assign col_full_c   = hcnt >> CELL_LOG2;
  assign row_full_c   = vcnt >> CELL_LOG2;
  assign in_range_c   = (32'(col_full_c) < HCELLS) && (32'(row_full_c) < VCELLS);
  assign lookup_idx_c = in_range_c ? IDX_W'(32'(row_full_c) * HCELLS + 32'(col_full_c))
                                   : '0;
  assign cur_idx_c    = IDX_W'(32'(cursor_row) * HCELLS + 32'(cursor_col));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      grid       <= '0;
      sweep      <= '0;
      painted    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      busy       <= 1'b0;
      pixel_cnt  <= '0;
      lk_idx     <= '0;
      lk_ok      <= 1'b0;
      on         <= 1'b0;
    end else begin
      lk_ok     <= in_range_c;
      lk_idx    <= lookup_idx_c;
      on        <= lk_ok & grid[lk_idx];
      pixel_cnt <= CNT_W'(painted) << (2 * CELL_LOG2);

      case (state)
        IDLE: begin
          if (|move_c) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (clear) begin
            state <= CLEAR;
            busy  <= 1'b1;
            sweep <= '0;
          end else begin
            // Write the pre-move cell; count only real 0<->1 transitions.
            if (pen) begin
              grid[cur_idx_c] <= ~erase;
              if (grid[cur_idx_c] == erase) begin
                painted <= erase ? painted - PC_W'(1) : painted + PC_W'(1);
              end
            end
            if (move_c[BTN_RIGHT]) begin
              cursor_col <= (cursor_col == COL_W'(HCELLS - 1)) ? '0 : cursor_col + COL_W'(1);
            end else if (move_c[BTN_LEFT]) begin
              cursor_col <= (cursor_col == '0) ? COL_W'(HCELLS - 1) : cursor_col - COL_W'(1);
            end else if (move_c[BTN_UP]) begin
              cursor_row <= (cursor_row == '0) ? ROW_W'(VCELLS - 1) : cursor_row - ROW_W'(1);
            end else if (move_c[BTN_DOWN]) begin
              cursor_row <= (cursor_row == ROW_W'(VCELLS - 1)) ? '0 : cursor_row + ROW_W'(1);
            end
          end
        end

        CLEAR: begin
          grid[sweep] <= 1'b0;
          if (sweep == IDX_W'(NCELLS - 1)) begin
            sweep   <= '0;
            painted <= '0;
            busy    <= 1'b0;
            state   <= RUN;
          end else begin
            sweep <= sweep + IDX_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paint_grid_tracker.sv
// Scoreboard bench for paint_grid_tracker: a cell-array model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_paint_grid_tracker;

  localparam int HC = 96;
  localparam int VC = 54;
  localparam int CL = 3;
  localparam int NC = HC * VC;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  btn = 4'd0;
  logic        pen = 1'b0;
  logic        erase = 1'b0;
  logic        clear = 1'b0;
  logic [13:0] hcnt = 14'd0;
  logic [11:0] vcnt = 12'd0;
  logic        on;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [19:0] pixel_cnt;

  paint_grid_tracker #(
    .HCELLS(96), .VCELLS(54), .CELL_LOG2(3), .CNT_W(20)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PushButton (btn),
    .pen        (pen),
    .erase      (erase),
    .clear      (clear),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .on         (on),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pixel_cnt  (pixel_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned edge_no;
    logic [6:0]  col;
    logic [5:0]  row;
    logic        busy;
    logic        on;
    logic [19:0] pcnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 clearing.
  bit          g[VC][HC];
  int          m_mode = 0;
  int          cc = 0;
  int          cr = 0;
  int          sweep_left = 0;
  int          cnt = 0;
  int          prev_cnt = 0;
  bit          prev_on = 1'b0;
  logic [3:0]  prevb = 4'd0;
  bit          cleared = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int popcount();
    int n = 0;
    foreach (g[i, j]) n += int'(g[i][j]);
    return n;
  endfunction

  function automatic void chk(string nm, int unsigned act, int unsigned exp_v, int unsigned en);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, en, act, exp_v);
    end
  endfunction

  // Apply the current inputs to the model, push the prediction, advance a cycle.
  task automatic step();
    exp_t       e;
    logic [3:0] edg;
    int         hx;
    int         vy;
    int         idx;
    e.edge_no = cyc + 1;
    if (!RESET) begin
      m_mode = 0;
      foreach (g[i, j]) g[i][j] = 1'b0;
      cc = 0; cr = 0; prevb = 4'd0; cnt = 0; sweep_left = 0;
      e.on = 1'b0;
      e.pcnt = 20'd0;
    end else begin
      edg = btn & ~prevb;
      prevb = btn;
      e.on = prev_on;
      e.pcnt = 20'(prev_cnt * 64);
      case (m_mode)
        0: if (edg != 4'd0) m_mode = 1;
        1: begin
          if (clear) begin
            m_mode = 2;
            sweep_left = NC;
          end else begin
            if (pen) begin
              g[cr][cc] = ~erase;
              cnt = popcount();
            end
            if (edg[0])      cc = (cc + 1) % HC;
            else if (edg[3]) cc = (cc + HC - 1) % HC;
            else if (edg[1]) cr = (cr + VC - 1) % VC;
            else if (edg[2]) cr = (cr + 1) % VC;
          end
        end
        default: begin
          idx = NC - sweep_left;
          g[idx / HC][idx % HC] = 1'b0;
          sweep_left--;
          if (sweep_left == 0) begin
            m_mode = 1;
            cnt = 0;
          end
        end
      endcase
    end
    e.col  = 7'(cc);
    e.row  = 6'(cr);
    e.busy = (m_mode == 2);
    q.push_back(e);
    if (!RESET) begin
      prev_on = 1'b0;
      prev_cnt = 0;
    end else begin
      hx = int'(hcnt) >> CL;
      vy = int'(vcnt) >> CL;
      prev_on = (hx < HC && vy < VC) ? g[vy][hx] : 1'b0;
      prev_cnt = cnt;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'd0;
    step();
  endtask

  // Monitor: compare each record once its clock edge has passed.
  always @(negedge CLK) begin
    exp_t m;
    while (q.size() > 0 && q[0].edge_no <= cyc) begin
      m = q.pop_front();
      chk("cursor_col", 32'(cursor_col), 32'(m.col), m.edge_no);
      chk("cursor_row", 32'(cursor_row), 32'(m.row), m.edge_no);
      chk("busy", 32'(busy), 32'(m.busy), m.edge_no);
      chk("on", 32'(on), 32'(m.on), m.edge_no);
      chk("pixel_cnt", 32'(pixel_cnt), 32'(m.pcnt), m.edge_no);
    end
  end

  initial begin
    RESET = 1'b0;
    hold(3);
    RESET = 1'b1;
    hold(2);

    // Arming, then wrap in all directions.
    press(4'b0001);
    press(4'b0001);
    press(4'b1000);
    press(4'b1000);
    press(4'b0010);
    press(4'b0100);
    press(4'b0001);

    // Repeated paint of one cell, paint while moving, then erase.
    pen = 1'b1;
    hold(5);
    btn = 4'b0001;
    step();
    btn = 4'd0;
    step();
    erase = 1'b1;
    step();
    pen = 1'b0;
    erase = 1'b0;
    hold(3);

    // Paint (2,1) and scan the raster across its boundaries.
    press(4'b0001);
    press(4'b0100);
    pen = 1'b1;
    step();
    pen = 1'b0;
    for (int h = 14; h <= 24; h++) begin
      hcnt = 14'(h);
      vcnt = 12'(8 + (h % 8));
      step();
    end
    hcnt = 14'd800;
    vcnt = 12'd8;
    step();
    hold(3);

    // Paint several cells, clear with buttons pressed mid-sweep.
    pen = 1'b1;
    press(4'b0001);
    press(4'b0001);
    pen = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    hold(100);
    press(4'b0001);
    press(4'b0010);
    pen = 1'b1;
    hold(20);
    pen = 1'b0;
    hold(NC - 120);
    for (int k = 0; k < 200; k++) begin
      hcnt = 14'($urandom_range(800));
      vcnt = 12'($urandom_range(450));
      step();
    end

    // Simultaneous right+left+up: right alone acts.
    btn = 4'b1011;
    step();
    btn = 4'd0;
    hold(2);

    // Randomized traffic with at most one clear sweep.
    for (int k = 0; k < 7000; k++) begin
      if ($urandom_range(3) == 0) btn = btn ^ (4'b0001 << $urandom_range(3));
      pen = ($urandom_range(2) == 0);
      erase = ($urandom_range(3) == 0);
      clear = (k < 1000) && !cleared && ($urandom_range(499) == 0);
      if (clear) cleared = 1'b1;
      if ($urandom_range(1) == 1) begin
        hcnt = 14'((cc << CL) + $urandom_range(7));
        vcnt = 12'((cr << CL) + $urandom_range(7));
      end else begin
        hcnt = 14'($urandom_range(1000));
        vcnt = 12'($urandom_range(600));
      end
      step();
    end
    btn = 4'd0;
    pen = 1'b0;
    erase = 1'b0;
    clear = 1'b0;
    hold(3);

    // Reset asserted in the middle of a clear sweep.
    pen = 1'b1;
    step();
    pen = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    hold(50);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    hold(3);
    press(4'b0001);
    hold(2);

    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
